sdram_rr_sched: RTL and testbench

- Shares the single SDRAM controller command port between three requesters: video fetch, CPU and DMA.
- Inserts auto-refresh cycles at a fixed interval and gives refresh priority over all requesters.
- Grants by round-robin, so no requester can starve another.
- Tells a requester that has held the port too long to yield. It never revokes a grant mid-transaction.

---
 rtl/sdram_rr_sched.sv | 137 +++++++++++++
 tb/tb_sdram_rr_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rr_sched.sv
// rtl/sdram_rr_sched.sv - round-robin SDRAM command-port scheduler with periodic refresh
module sdram_rr_sched #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_HOLD         = 64,
  parameter int PEND_MAX         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [2:0] yield,
  output logic       ref_req,
  input  logic       ref_ack,
  output logic       ref_ovf
);

  typedef enum logic [1:0] {IDLE, GRANT, REFRESH} state_t;

  localparam logic [15:0] TICK_LAST = 16'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]  PEND_LIM  = 3'(PEND_MAX);
  localparam logic [7:0]  HOLD_LIM  = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  pend_q, pend_d;
  logic [7:0]  hold_q, hold_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  yield_q, yield_d;

  logic       tick, ack_ok;
  logic [2:0] owner_oh, others;
  logic [1:0] pick;

  assign owner_oh = 3'b001 << owner_q;
  assign others   = req & ~owner_oh;

  // Search order starts just after the last owner, so the previous holder goes last.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    ack_ok     = ref_ack && (state_q == REFRESH);
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    if (tick && !ack_ok) begin
      if (pend_q == PEND_LIM) ovf_d  = 1'b1;
      else                    pend_d = pend_q + 3'd1;
    end else if (ack_ok && !tick && pend_q != 3'd0) begin
      pend_d = pend_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    yield_d = yield_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 3'd0) begin
          state_d = REFRESH;
        end else if (|req) begin
          state_d = GRANT;
          owner_d = pick;
          hold_d  = 8'd0;
          yield_d = 3'b000;
        end
      end
      GRANT: begin
        if (!(|(req & owner_oh))) begin
          state_d = IDLE;
          last_d  = owner_q;
          hold_d  = 8'd0;
          yield_d = 3'b000;
        end else begin
          hold_d = (hold_q >= HOLD_LIM) ? HOLD_LIM : hold_q + 8'd1;
          if (hold_d >= HOLD_LIM && (pend_q != 3'd0 || |others)) yield_d = owner_oh;
        end
      end
      REFRESH: begin
        if (ack_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      tick_cnt_q <= 16'd0;
      pend_q     <= 3'd0;
      hold_q     <= 8'd0;
      ovf_q      <= 1'b0;
      yield_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      ovf_q      <= ovf_d;
      yield_q    <= yield_d;
    end
  end

  assign gnt     = (state_q == GRANT) ? owner_oh : 3'b000;
  assign ref_req = (state_q == REFRESH);
  assign yield   = yield_q;
  assign ref_ovf = ovf_q;

endmodule

// File: tb/tb_sdram_rr_sched.sv
// tb/tb_sdram_rr_sched.sv - randomized self-checking bench for sdram_rr_sched
module tb_sdram_rr_sched;
  localparam int RI = 12;
  localparam int MH = 4;
  localparam int PM = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       ref_ack = 1'b0;
  logic [2:0] gnt, yield;
  logic       ref_req, ref_ovf;

  sdram_rr_sched #(.REFRESH_INTERVAL(RI), .MAX_HOLD(MH), .PEND_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .yield(yield),
    .ref_req(ref_req), .ref_ack(ref_ack), .ref_ovf(ref_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 = idle, 1 = granted, 2 = refreshing
  int m_state, m_owner, m_last, m_cyc, m_pend, m_hold;
  bit m_ovf, m_yield;
  int glog[$];
  logic [2:0] prev_g;

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_last = 2; m_cyc = 0;
    m_pend = 0; m_hold = 0; m_ovf = 0; m_yield = 0;
    prev_g = 3'b000;
  endtask

  function automatic logic [2:0] exp_gnt();
    return (m_state == 1) ? 3'(1 << m_owner) : 3'b000;
  endfunction

  task automatic model_step(input logic [2:0] r, input logic a);
    bit tick, acc;
    int old_pend;
    tick = ((m_cyc % RI) == RI - 1);
    m_cyc++;
    acc = a && (m_state == 2);
    old_pend = m_pend;
    if (tick && !acc) begin
      if (m_pend == PM) m_ovf = 1;
      else m_pend++;
    end else if (acc && !tick) begin
      m_pend--;
    end
    case (m_state)
      0: begin
        if (old_pend > 0) m_state = 2;
        else if (r != 3'b000) begin
          for (int k = 1; k <= 3; k++) begin
            if (r[(m_last + k) % 3]) begin
              m_owner = (m_last + k) % 3;
              break;
            end
          end
          m_state = 1; m_hold = 0; m_yield = 0;
        end
      end
      1: begin
        if (!r[m_owner]) begin
          m_state = 0; m_last = m_owner; m_hold = 0; m_yield = 0;
        end else begin
          if (m_hold < MH) m_hold++;
          if (m_hold >= MH && (old_pend > 0 || (r & ~3'(1 << m_owner)) != 3'b000)) m_yield = 1;
        end
      end
      default: if (acc) m_state = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("gnt", gnt, exp_gnt());
    chk("yield", yield, m_yield ? 3'(1 << m_owner) : 3'b000);
    chk("ref_req", ref_req, m_state == 2);
    chk("ref_ovf", ref_ovf, m_ovf);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("gnt_and_ref", (|gnt) && ref_req, 0);
  endtask

  task automatic cycle(input logic [2:0] r, input logic a);
    req = r;
    ref_ack = a;
    @(posedge clk);
    model_step(r, a);
    @(negedge clk);
    check_outputs();
    if (prev_g == 3'b000 && exp_gnt() != 3'b000) glog.push_back(m_owner);
    prev_g = exp_gnt();
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_yield"}, yield, 0);
    chk({tag, "_ref_req"}, ref_req, 0);
    chk({tag, "_ref_ovf"}, ref_ovf, 0);
    model_reset();
    req = 3'b000;
    ref_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  logic [2:0] cur;
  int held;
  bit want [3];
  int len [3];

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // All three requesting: grants must rotate 0,1,2
    glog.delete();
    cur = 3'b111;
    held = 0;
    for (int i = 0; i < 80 && cur != 3'b000; i++) begin
      if (m_state == 1) begin
        held++;
        if (held >= 2) begin
          cur[m_owner] = 1'b0;
          held = 0;
        end
      end
      cycle(cur, m_state == 2);
    end
    chk("order_done", cur, 0);
    chk("order_len", glog.size(), 3);
    for (int i = 0; i < glog.size() && i < 3; i++) chk("order_idx", glog[i], i);

    // Long CPU hold with no refresh acks: pend saturates, overflow sticks
    for (int i = 0; i < 45; i++) cycle(3'b010, 1'b0);
    chk("ovf_after_sat", ref_ovf, 1);

    // Release, then reset in the middle of the refresh that follows
    for (int i = 0; i < 20 && m_state != 2; i++) cycle(3'b000, 1'b0);
    chk("wait_refresh", ref_req, 1);
    async_reset("rst_refresh");
    for (int i = 0; i < 20 && m_state != 1; i++) cycle(3'b111, 1'b0);
    chk("post_rst1_first", gnt, 3'b001);

    // Reset in the middle of a grant
    async_reset("rst_grant");
    for (int i = 0; i < 20 && m_state != 1; i++) cycle(3'b111, m_state == 2);
    chk("post_rst2_first", gnt, 3'b001);
    for (int i = 0; i < 4; i++) cycle(3'b000, m_state == 2);

    // DMA holds, video joins: yield must assert after MAX_HOLD grant cycles
    cur = 3'b100;
    for (int i = 0; i < 26; i++) begin
      if (i == 2) cur[0] = 1'b1;
      if (i == 22) cur[2] = 1'b0;
      cycle(cur, m_state == 2);
    end
    for (int i = 0; i < 6; i++) cycle(3'b000, m_state == 2);

    // Randomized traffic with random and spurious refresh acks
    for (int i = 0; i < 3; i++) begin
      want[i] = 0;
      len[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (want[i]) begin
          if (m_state == 1 && m_owner == i) begin
            len[i]--;
            if (len[i] <= 0) want[i] = 0;
          end
        end else if ($urandom % 4 == 0) begin
          want[i] = 1;
          len[i] = ($urandom % 8 == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 6));
        end
      end
      cycle({want[2], want[1], want[0]},
            (m_state == 2) ? ($urandom % 3 == 0) : ($urandom % 16 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
